// File: rtl/vend_credit_ctrl.sv
// Coffee vending credit/dispense controller: edge-detected buttons, credit in
// 100-unit coins, coffee strobe, and a one-coin-at-a-time ejector handshake.
module vend_credit_ctrl #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 8,
  parameter int C500       = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       B100,
  input  logic       B500,
  input  logic       BCf,
  input  logic       BRt,
  input  logic       EJ_ACK,
  output logic       SCf,
  output logic [3:0] Credit,
  output logic       EJ_REQ,
  output logic [3:0] Coin,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [4:0] C500_W  = 5'(C500);
  localparam logic [4:0] MAX_W   = 5'(MAX_CREDIT);
  localparam logic [3:0] PRICE_W = 4'(PRICE);

  state_t     state;
  logic       b100_q, b500_q, bcf_q, brt_q;
  logic       ev_b100, ev_b500, ev_bcf, ev_brt;
  logic [4:0] sum;

  // Credit plus the inserted coin, one bit wider so overflow is visible.
  function automatic logic [4:0] add_coin(input logic [3:0] credit,
                                          input logic       is_500);
    add_coin = {1'b0, credit} + (is_500 ? C500_W : 5'd1);
  endfunction

  always_comb begin
    ev_b100 = B100 & ~b100_q;
    ev_b500 = B500 & ~b500_q;
    ev_bcf  = BCf  & ~bcf_q;
    ev_brt  = BRt  & ~brt_q;
    sum     = add_coin(Credit, ev_b500);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      b100_q <= 1'b0;
      b500_q <= 1'b0;
      bcf_q  <= 1'b0;
      brt_q  <= 1'b0;
      SCf    <= 1'b0;
      Credit <= 4'd0;
      EJ_REQ <= 1'b0;
      Coin   <= 4'd0;
      Busy   <= 1'b0;
    end else begin
      b100_q <= B100;
      b500_q <= B500;
      bcf_q  <= BCf;
      brt_q  <= BRt;
      SCf    <= 1'b0;
      case (state)
        IDLE: begin
          // Priority chain: the winning event consumes the cycle even if it has no effect.
          if (ev_brt) begin
            if (Credit != 4'd0) begin
              Coin   <= Credit;
              Credit <= 4'd0;
              state  <= REQ;
              EJ_REQ <= 1'b1;
              Busy   <= 1'b1;
            end
          end else if (ev_bcf) begin
            if (Credit >= PRICE_W) begin
              Credit <= Credit - PRICE_W;
              SCf    <= 1'b1;
            end
          end else if (ev_b500 || ev_b100) begin
            if (sum <= MAX_W) begin
              Credit <= sum[3:0];
            end else begin
              Coin   <= sum[3:0];
              Credit <= 4'd0;
              state  <= REQ;
              EJ_REQ <= 1'b1;
              Busy   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (EJ_ACK) begin
            Coin   <= Coin - 4'd1;
            EJ_REQ <= 1'b0;
            if (Coin == 4'd1) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          state  <= REQ;
          EJ_REQ <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          EJ_REQ <= 1'b0;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with hand-computed expected values.
module tb_vend_credit_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] btn = 4'b0000;  // {BRt, BCf, B500, B100}
  logic       EJ_ACK = 1'b0;
  logic       SCf, EJ_REQ, Busy;
  logic [3:0] Credit, Coin;
  logic       scf_mid;
  int         checks = 0;
  int         errors = 0;

  localparam logic [3:0] K100 = 4'b0001, K500 = 4'b0010, KCF = 4'b0100, KRT = 4'b1000;

  vend_credit_ctrl #(.PRICE(3), .MAX_CREDIT(8), .C500(5)) dut (
    .CLK(CLK), .RST(RST),
    .B100(btn[0]), .B500(btn[1]), .BCf(btn[2]), .BRt(btn[3]),
    .EJ_ACK(EJ_ACK),
    .SCf(SCf), .Credit(Credit), .EJ_REQ(EJ_REQ), .Coin(Coin), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise the masked buttons for two cycles; SCf is captured one cycle after the edge.
  task automatic press(input logic [3:0] mask);
    @(negedge CLK) btn = mask;
    @(negedge CLK) scf_mid = SCf;
    @(negedge CLK) btn = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
  endtask

  task automatic eject_all(input int n);
    for (int k = n; k >= 1; k--) begin
      int t = 0;
      while (!EJ_REQ && t < 20) begin
        @(negedge CLK);
        t++;
      end
      check("ej_req_seen", EJ_REQ, 1);
      check("coin_before_ack", Coin, k);
      check("busy_in_req", Busy, 1);
      EJ_ACK = 1'b1;
      @(negedge CLK) EJ_ACK = 1'b0;
      check("coin_after_ack", Coin, k - 1);
      check("ej_req_dropped", EJ_REQ, 0);
      check("busy_after_ack", Busy, (k > 1) ? 1 : 0);
    end
    @(negedge CLK);
    check("idle_ej_req", EJ_REQ, 0);
    check("idle_busy", Busy, 0);
    check("idle_credit", Credit, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_credit", Credit, 0);
    check("rst_coin", Coin, 0);
    check("rst_scf", SCf, 0);
    check("rst_ej_req", EJ_REQ, 0);
    check("rst_busy", Busy, 0);

    // 1: eight 100 coins then coffee
    for (int i = 1; i <= 8; i++) begin
      press(K100);
      check("t1_credit", Credit, i);
    end
    check("t1_busy", Busy, 0);
    press(KCF);
    check("t1_scf_pulse", scf_mid, 1);
    check("t1_scf_low", SCf, 0);
    check("t1_credit_after", Credit, 5);

    // 2: 500 + 3x100, two coffees, third refused
    do_reset();
    check("t2_rst_credit", Credit, 0);
    press(K500);
    check("t2_500", Credit, 5);
    for (int i = 0; i < 3; i++) press(K100);
    check("t2_full", Credit, 8);
    press(KCF);
    check("t2_scf1", scf_mid, 1);
    check("t2_credit1", Credit, 5);
    press(KCF);
    check("t2_scf2", scf_mid, 1);
    check("t2_credit2", Credit, 2);
    press(KCF);
    check("t2_scf_refused", scf_mid, 0);
    check("t2_credit_kept", Credit, 2);

    // 3: nine 100 coins overflow, all nine returned
    do_reset();
    for (int i = 0; i < 9; i++) press(K100);
    check("t3_credit", Credit, 0);
    check("t3_coin", Coin, 9);
    check("t3_busy", Busy, 1);
    eject_all(9);

    // 4: 7x100 + 500 overflow, then 100+500 returned
    for (int i = 0; i < 7; i++) press(K100);
    check("t4_credit7", Credit, 7);
    press(K500);
    check("t4_coin12", Coin, 12);
    check("t4_credit0", Credit, 0);
    eject_all(12);
    press(K100);
    press(K500);
    check("t4_credit6", Credit, 6);
    press(KRT);
    check("t4_coin6", Coin, 6);
    eject_all(6);
    press(KRT);
    check("t4_rt_empty_busy", Busy, 0);
    check("t4_rt_empty_coin", Coin, 0);

    // 5: stalled ejector, ignored press while busy, reset mid-return
    press(K100);
    press(K100);
    press(KRT);
    repeat (5) @(negedge CLK);
    check("t5_ej_req_held", EJ_REQ, 1);
    check("t5_coin", Coin, 2);
    press(K100);
    check("t5_busy_coin", Coin, 2);
    check("t5_busy_credit", Credit, 0);
    check("t5_busy_flag", Busy, 1);
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_coin", Coin, 0);
    check("t5_rst_ej_req", EJ_REQ, 0);
    check("t5_rst_busy", Busy, 0);
    check("t5_rst_credit", Credit, 0);
    check("t5_rst_scf", SCf, 0);
    // Button held through reset counts as a fresh press on release.
    btn = K100;
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    check("t5_held_through_rst", Credit, 1);
    btn = 4'b0000;
    @(negedge CLK);

    // 6: simultaneous B100+BRt, then a long hold counts once
    press(K100);
    press(K100);
    check("t6_credit3", Credit, 3);
    press(K100 | KRT);
    check("t6_coin3", Coin, 3);
    check("t6_credit0", Credit, 0);
    eject_all(3);
    @(negedge CLK) btn = K100;
    repeat (10) @(negedge CLK);
    check("t6_hold_credit", Credit, 1);
    btn = 4'b0000;
    repeat (2) @(negedge CLK);
    check("t6_hold_after", Credit, 1);
    press(KCF | K100);
    check("t6_bcf_wins_credit", Credit, 1);
    check("t6_bcf_wins_scf", scf_mid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
